// File: rtl/lock_key_loader.sv
// lock_key_loader: takes a key MSB-first over valid/ready, checks it against ALLOW_MASK, and drives the registered key bus D.
// Latency: D/key_valid update KEY_W+1 edges after the load_start edge when bits arrive back to back.
// Backpressure: key_bit_ready is high only in SHIFT, so IDLE/CHECK/ARMED stall the sender; the bus only ever shows DEFAULT_KEY or a checked code.
module lock_key_loader #(
  parameter int                  KEY_W       = 2,
  parameter logic [2**KEY_W-1:0] ALLOW_MASK  = 4'b0111,
  parameter logic [KEY_W-1:0]    DEFAULT_KEY = '0,
  parameter int                  TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             key_bit,
  input  logic             key_bit_valid,
  output logic             key_bit_ready,
  output logic [KEY_W-1:0] D,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);
  localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, ARMED} state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       idle_cnt;
  logic [KEY_W-1:0] shreg;
  logic             accept;

  // Ready depends only on state, so the sender sees it in the same cycle.
  assign key_bit_ready = (state == SHIFT);
  assign accept        = key_bit_ready & key_bit_valid;

  // Load sequencer: the partial key lives only in shreg; D changes solely in CHECK or on a (re)load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      shreg     <= '0;
      D         <= DEFAULT_KEY;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, ARMED: begin
          if (load_start) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            shreg     <= '0;
            key_err   <= 1'b0;
            key_valid <= 1'b0;
            D         <= DEFAULT_KEY;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (load_start) begin
            // Restart wins over a bit offered in the same cycle.
            bit_cnt  <= '0;
            idle_cnt <= '0;
            shreg    <= '0;
          end else if (accept) begin
            shreg    <= {shreg[KEY_W-2:0], key_bit};
            bit_cnt  <= bit_cnt + CNT_W'(1);
            idle_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              state <= CHECK;
            end
          end else if (idle_cnt == TO_LAST) begin
            // This edge completes the last allowed idle cycle.
            state    <= IDLE;
            idle_cnt <= '0;
            key_err  <= 1'b1;
            busy     <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        CHECK: begin
          busy <= 1'b0;
          if (ALLOW_MASK[shreg]) begin
            state     <= ARMED;
            D         <= shreg;
            key_valid <= 1'b1;
          end else begin
            state   <= IDLE;
            key_err <= 1'b1;
            D       <= DEFAULT_KEY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_key_loader.sv
// Bench for lock_key_loader: scenario tasks push expected load outcomes to a queue and pop them when busy falls.
// Inputs are driven and outputs sampled on the falling clock edge.
// A background monitor checks that D is never 11 and that ready is never high outside a load.
module tb_lock_key_loader;

  logic       clk;
  logic       rst_n;
  logic       load_start;
  logic       key_bit;
  logic       key_bit_valid;
  logic       key_bit_ready;
  logic [1:0] D;
  logic       key_valid;
  logic       key_err;
  logic       busy;

  typedef struct packed {
    logic [1:0] d;
    logic       v;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   asserts = 0;
  int   fails   = 0;
  logic mon_en  = 1'b0;

  lock_key_loader #(
    .KEY_W(2),
    .ALLOW_MASK(4'b0111),
    .DEFAULT_KEY(2'b00),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_start(load_start),
    .key_bit(key_bit),
    .key_bit_valid(key_bit_valid),
    .key_bit_ready(key_bit_ready),
    .D(D),
    .key_valid(key_valid),
    .key_err(key_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Invariants that hold in every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      asserts++;
      if (D === 2'b11) begin
        fails++;
        $display("FAIL mon_forbidden_D: D=%b required not 11 at %0t", D, $time);
      end
      asserts++;
      if (!busy && key_bit_ready !== 1'b0) begin
        fails++;
        $display("FAIL mon_ready_idle: key_bit_ready=%b required 0 while not busy at %0t", key_bit_ready, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus drivers (called at a falling edge, return at a falling edge).
  task automatic pulse_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    int n;
    key_bit_valid = 1'b0;
    repeat (gap) @(negedge clk);
    key_bit_valid = 1'b1;
    key_bit       = b;
    n = 0;
    while (key_bit_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      asserts++;
      fails++;
      $display("FAIL send_bit_ready: key_bit_ready=%b required 1 within 50 cycles", key_bit_ready);
    end
    @(negedge clk);
    key_bit_valid = 1'b0;
  endtask

  // Waits for the load to finish, then pops and compares the expected outcome.
  task automatic wait_done(input string name);
    int   n;
    exp_t e;
    exp_t got;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    asserts++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_busy: busy=%b required 0 within 100 cycles", name, busy);
    end
    asserts++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s_sb: scoreboard empty, required one expected entry", name);
    end else begin
      e   = sb.pop_front();
      got = '{d: D, v: key_valid, e: key_err};
      if (got !== e) begin
        fails++;
        $display("FAIL %s_result: D=%b key_valid=%b key_err=%b required D=%b key_valid=%b key_err=%b",
                 name, got.d, got.v, got.e, e.d, e.v, e.e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_start = 1'b0; key_bit = 1'b0; key_bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    asserts++;
    if ({D, key_valid, key_err, busy, key_bit_ready} !== 6'b00_0000) begin
      fails++;
      $display("FAIL reset_values: D=%b kv=%b ke=%b busy=%b rdy=%b required all 0",
               D, key_valid, key_err, busy, key_bit_ready);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_10();
    sb.push_back('{d: 2'b10, v: 1'b1, e: 1'b0});
    pulse_load();                       // edge 1 samples load_start
    asserts++;
    if (key_bit_ready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL load10_shift: rdy=%b busy=%b required 1 1", key_bit_ready, busy);
    end
    send_bit(1'b1, 0);                  // accepted on edge 2
    send_bit(1'b0, 0);                  // accepted on edge 3 -> CHECK
    asserts++;
    if (key_bit_ready !== 1'b0 || busy !== 1'b1 || key_valid !== 1'b0 || D !== 2'b00) begin
      fails++;
      $display("FAIL load10_check: rdy=%b busy=%b kv=%b D=%b required 0 1 0 00",
               key_bit_ready, busy, key_valid, D);
    end
    @(negedge clk);                     // edge 4 = 3 edges after the load edge
    asserts++;
    if (D !== 2'b10 || key_valid !== 1'b1) begin
      fails++;
      $display("FAIL load10_latency: D=%b kv=%b required 10 1 three edges after load", D, key_valid);
    end
    wait_done("load10");
  endtask

  task automatic test_forbidden();
    sb.push_back('{d: 2'b00, v: 1'b0, e: 1'b1});
    pulse_load();
    asserts++;
    if (key_valid !== 1'b0 || D !== 2'b00) begin
      fails++;
      $display("FAIL forbid_drop: kv=%b D=%b required 0 00 after load edge", key_valid, D);
    end
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    wait_done("forbid11");
  endtask

  task automatic test_timeout();
    sb.push_back('{d: 2'b01, v: 1'b1, e: 1'b0});
    pulse_load();
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    wait_done("arm01");
    sb.push_back('{d: 2'b00, v: 1'b0, e: 1'b1});
    pulse_load();
    send_bit(1'b1, 0);
    repeat (15) @(negedge clk);
    asserts++;
    if (busy !== 1'b1 || key_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_early: busy=%b ke=%b after 15 idle cycles required 1 0", busy, key_err);
    end
    @(negedge clk);
    asserts++;
    if (busy !== 1'b0 || key_err !== 1'b1 || D !== 2'b00 || key_bit_ready !== 1'b0) begin
      fails++;
      $display("FAIL timeout_fire: busy=%b ke=%b D=%b rdy=%b after 16 idle cycles required 0 1 00 0",
               busy, key_err, D, key_bit_ready);
    end
    wait_done("timeout");
  endtask

  task automatic test_restart();
    sb.push_back('{d: 2'b01, v: 1'b1, e: 1'b0});
    pulse_load();
    asserts++;
    if (key_err !== 1'b0) begin
      fails++;
      $display("FAIL restart_errclr: key_err=%b required 0 after load_start", key_err);
    end
    send_bit(1'b1, 0);
    load_start = 1'b1; key_bit_valid = 1'b1; key_bit = 1'b1;
    @(negedge clk);
    load_start = 1'b0; key_bit_valid = 1'b0;
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    wait_done("restart");
  endtask

  task automatic test_reset_in_check();
    pulse_load();
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);                  // now in CHECK
    rst_n = 1'b0;
    #1;
    asserts++;
    if (D !== 2'b00 || key_valid !== 1'b0 || busy !== 1'b0 || key_bit_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: D=%b kv=%b busy=%b rdy=%b required 00 0 0 0",
               D, key_valid, busy, key_bit_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    asserts++;
    if (D !== 2'b00 || key_valid !== 1'b0 || key_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_release: D=%b kv=%b ke=%b required 00 0 0", D, key_valid, key_err);
    end
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 4; r++) begin
      sb.push_back('{d: 2'b01, v: 1'b1, e: 1'b0});
      pulse_load();
      send_bit(1'b0, int'($urandom_range(6, 0)));
      send_bit(1'b1, int'($urandom_range(6, 0)));
      wait_done("gaps01");
      repeat (int'($urandom_range(3, 0))) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    sb.push_back('{d: 2'b10, v: 1'b1, e: 1'b0});
    pulse_load();
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    wait_done("b2b_10");
    sb.push_back('{d: 2'b00, v: 1'b1, e: 1'b0});
    pulse_load();
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    wait_done("b2b_00");
  endtask

  initial begin
    test_reset();
    test_load_10();
    test_forbidden();
    test_timeout();
    test_restart();
    test_reset_in_check();
    test_gaps();
    test_back_to_back();
    asserts++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
